// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command front end.
//   rx_state_t  - RX deserializer states
//   tx_state_t  - TX serializer states
//   cmd_state_t - byte-pair command assembly states
//   DATA_BITS   - bits per UART character
//   half_bit()  - wait (in cycles) from start-bit edge to mid-start-bit sample
package uart_cmd_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_W     = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        WAIT_HIGH,
        WAIT_LOW,
        CMD_VALID
    } cmd_state_t;

    function automatic int half_bit(input int baud_div);
        return baud_div / 2;
    endfunction

endpackage

// File: rtl/uart_cmd_if_if.sv
// uart_cmd_if_if: command/response handshake between the UART front end and
// the command/config block.
//   cmd[15:0]    - assembled command (front end -> consumer)
//   cmd_rdy      - cmd valid and held stable
//   clr_cmd_rdy  - consumer releases the command
//   resp[7:0]    - byte to transmit (consumer -> front end)
//   send_resp    - request transmission of resp
//   resp_sent    - one-cycle pulse when the stop bit completes
// Modports: master = UART front end, slave = command/config block.
import uart_cmd_pkg::*;

interface uart_cmd_if_if;
    logic [2*DATA_BITS-1:0] cmd;
    logic                   cmd_rdy;
    logic                   clr_cmd_rdy;
    logic [DATA_BITS-1:0]   resp;
    logic                   send_resp;
    logic                   resp_sent;

    modport master (
        output cmd, cmd_rdy, resp_sent,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd, cmd_rdy, resp_sent,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer.
//   clk, rst   - system clock, synchronous active-high reset
//   resp       - byte to send, captured when send_resp is accepted in IDLE
//   send_resp  - transmit request, ignored unless IDLE
//   TX         - serial line, idle high
//   resp_sent  - one-cycle pulse in the cycle the FSM re-enters IDLE
import uart_cmd_pkg::*;

module uart_tx #(
    parameter int BAUD_DIV = 1736
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] resp,
    input  logic                 send_resp,
    output logic                 TX,
    output logic                 resp_sent
);
    localparam int               CNT_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    tx_state_t            state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 bit_done;

    assign bit_done = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= TX_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (send_resp) state_next = TX_START;
            TX_START: if (bit_done)  state_next = TX_DATA;
            TX_DATA:  if (bit_done && bit_idx == BIT_LAST) state_next = TX_STOP;
            TX_STOP:  if (bit_done)  state_next = TX_IDLE;
            default:  state_next = TX_IDLE;
        endcase
    end

    // Line level is a pure function of state, so a reset returns TX high
    // in the very next cycle.
    always_comb begin
        case (state)
            TX_START: TX = 1'b0;
            TX_DATA:  TX = shift[0];
            default:  TX = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= (state == TX_STOP) && bit_done;
            if (state == TX_IDLE || bit_done) cnt <= '0;
            else                              cnt <= cnt + 1'b1;
            if (state == TX_DATA && bit_done) bit_idx <= bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == TX_IDLE && send_resp)
            shift <= resp;
        else if (state == TX_DATA && bit_done)
            shift <= {1'b0, shift[DATA_BITS-1:1]};
    end

endmodule

// File: rtl/uart_cmd_if.sv
// uart_cmd_if: host-side serial front end. Deserializes RX into bytes, pairs
// them into a 16-bit command held under a cmd_rdy/clr_cmd_rdy handshake, and
// serializes response bytes onto TX through uart_tx.
//   clk, rst - system clock, synchronous active-high reset
//   RX       - asynchronous serial input, idle high
//   TX       - serial output, idle high
//   bus      - uart_cmd_if_if.master (cmd, cmd_rdy, clr_cmd_rdy, resp,
//              send_resp, resp_sent)
// Build option: define CMD_TIMEOUT_EN to abandon a lone high byte after
// TIMEOUT_CYCLES without a second byte.
import uart_cmd_pkg::*;

module uart_cmd_if #(
    parameter int BAUD_DIV       = 1736,
    parameter int TIMEOUT_CYCLES = 55552
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           RX,
    output logic           TX,
    uart_cmd_if_if.master  bus
);
    localparam int               CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit(BAUD_DIV) - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // ---------------- RX deserializer ----------------
    logic                 rx_s1, rx_s2, rx_prev;
    rx_state_t            rx_state, rx_next;
    logic [CNT_W-1:0]     rx_cnt;
    logic [BIT_W-1:0]     rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick, rx_fall, rx_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;
    // START only waits half a bit so every later sample lands mid-bit.
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST)
                                            : (rx_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == BIT_LAST) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Combinational so the command FSM captures on the stop-sample edge.
    always_comb begin
        rx_rdy = (rx_state == RX_STOP) && rx_tick && rx_s2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_cnt <= '0;
            rx_bit <= '0;
        end else begin
            if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
            else                                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_IDLE)                rx_bit <= '0;
            else if (rx_state == RX_DATA && rx_tick) rx_bit <= rx_bit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_tick)
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
    end

    // ---------------- Command assembly ----------------
    cmd_state_t             cmd_state, cmd_next;
    logic [2*DATA_BITS-1:0] cmd_reg;
    logic                   timeout;

`ifdef CMD_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]      to_cnt;
    logic [DATA_BITS-1:0] hi_byte;

    // Restarts on every entry to WAIT_LOW because it is held at zero elsewhere.
    always_ff @(posedge clk) begin
        if (rst || cmd_state != WAIT_LOW) to_cnt <= '0;
        else                              to_cnt <= to_cnt + 1'b1;
    end
    assign timeout = (cmd_state == WAIT_LOW) && (to_cnt == TO_LAST);

    // High byte is staged so an abandoned pair leaves cmd untouched.
    always_ff @(posedge clk) begin
        if (cmd_state == WAIT_HIGH && rx_rdy) hi_byte <= rx_shift;
    end
`else
    // Parameter is kept so both builds instantiate identically.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) cmd_state <= WAIT_HIGH;
        else     cmd_state <= cmd_next;
    end

    always_comb begin
        cmd_next = cmd_state;
        case (cmd_state)
            WAIT_HIGH: if (rx_rdy) cmd_next = WAIT_LOW;
            WAIT_LOW: begin
                if (rx_rdy)       cmd_next = CMD_VALID;
                else if (timeout) cmd_next = WAIT_HIGH;
            end
            // Any rx_rdy here, including one coincident with the clear, is dropped.
            CMD_VALID: if (bus.clr_cmd_rdy) cmd_next = WAIT_HIGH;
            default:   cmd_next = WAIT_HIGH;
        endcase
    end

    always_comb begin
        bus.cmd_rdy = (cmd_state == CMD_VALID);
        bus.cmd     = cmd_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_reg <= '0;
        end else if (rx_rdy) begin
            case (cmd_state)
`ifdef CMD_TIMEOUT_EN
                WAIT_LOW:  cmd_reg <= {hi_byte, rx_shift};
`else
                WAIT_HIGH: cmd_reg[2*DATA_BITS-1:DATA_BITS] <= rx_shift;
                WAIT_LOW:  cmd_reg[DATA_BITS-1:0]           <= rx_shift;
`endif
                default: ;
            endcase
        end
    end

    // ---------------- TX serializer ----------------
    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .resp      (bus.resp),
        .send_resp (bus.send_resp),
        .TX        (TX),
        .resp_sent (bus.resp_sent)
    );

endmodule

// File: tb/tb_uart_cmd_if.sv
// tb_uart_cmd_if: directed bench for uart_cmd_if at BAUD_DIV=16,
// TIMEOUT_CYCLES=800. Expected timeout result depends on CMD_TIMEOUT_EN.
module tb_uart_cmd_if;
    localparam int BAUD = 16;
    localparam int TO   = 800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RX  = 1'b1;
    logic TX;
    int   errors = 0;
    int   checks = 0;

    uart_cmd_if_if bus();

    uart_cmd_if #(.BAUD_DIV(BAUD), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .RX  (RX),
        .TX  (TX),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        wait_cycles(BAUD);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_cycles(BAUD);
        end
        RX = stop_bit;
        wait_cycles(BAUD);
        RX = 1'b1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j >= 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.resp        = 8'h00;
        wait_cycles(4);
        rst = 1'b0;
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", TX); end
        checks++; if (bus.cmd !== 16'h0000) begin errors++; $display("FAIL reset_cmd got=%h exp=0000", bus.cmd); end
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy got=%b exp=0", bus.cmd_rdy); end
        checks++; if (bus.resp_sent !== 1'b0) begin errors++; $display("FAIL reset_resp_sent got=%b exp=0", bus.resp_sent); end
        wait_cycles(2);
    endtask

    task automatic pulse_clear(input string name);
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL %s_before_clr got=%b exp=1", name, bus.cmd_rdy); end
        bus.clr_cmd_rdy = 1'b1;
        wait_cycles(1);
        bus.clr_cmd_rdy = 1'b0;
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL %s_after_clr got=%b exp=0", name, bus.cmd_rdy); end
    endtask

    task automatic test_cmd;
        send_byte(8'h46, 1'b1);
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL cmd_half got=%b exp=0", bus.cmd_rdy); end
        send_byte(8'h0C, 1'b1);
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL cmd_rdy_set got=%b exp=1", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 16'h460C) begin errors++; $display("FAIL cmd_460c got=%h exp=460c", bus.cmd); end
        wait_cycles(30);
        checks++; if (bus.cmd_rdy !== 1'b1) begin errors++; $display("FAIL cmd_rdy_hold got=%b exp=1", bus.cmd_rdy); end
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        checks++; if (bus.cmd !== 16'h460C) begin errors++; $display("FAIL cmd_frozen got=%h exp=460c", bus.cmd); end
        pulse_clear("cmd1");
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        checks++; if (bus.cmd !== 16'hABCD) begin errors++; $display("FAIL cmd_abcd got=%h exp=abcd", bus.cmd); end
        pulse_clear("cmd2");
    endtask

    task automatic test_rx_errors;
        RX = 1'b0;
        wait_cycles(4);
        RX = 1'b1;
        wait_cycles(40);
        send_byte(8'h55, 1'b0);
        wait_cycles(20);
        checks++; if (bus.cmd_rdy !== 1'b0) begin errors++; $display("FAIL rx_err_rdy got=%b exp=0", bus.cmd_rdy); end
        checks++; if (bus.cmd !== 16'hABCD) begin errors++; $display("FAIL rx_err_cmd got=%h exp=abcd", bus.cmd); end
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        checks++; if (bus.cmd !== 16'h1122) begin errors++; $display("FAIL rx_err_pair got=%h exp=1122", bus.cmd); end
        pulse_clear("rx_err");
    endtask

    task automatic test_timeout;
        logic [15:0] exp;
`ifdef CMD_TIMEOUT_EN
        exp = 16'h0203;
`else
        exp = 16'h8102;
`endif
        send_byte(8'h81, 1'b1);
        wait_cycles(TO);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        checks++; if (bus.cmd !== exp) begin errors++; $display("FAIL timeout_cmd got=%h exp=%h", bus.cmd, exp); end
        pulse_clear("timeout");
    endtask

    task automatic test_tx;
        int  sent_at;
        logic exp;
        bus.resp = 8'hA5;
        bus.send_resp = 1'b1;
        wait_cycles(1);
        bus.send_resp = 1'b0;
        checks++; if (TX !== 1'b0) begin errors++; $display("FAIL tx_fall got=%b exp=0", TX); end
        sent_at = -1;
        for (int k = 1; k <= 200 && sent_at < 0; k++) begin
            wait_cycles(1);
            bus.send_resp = 1'b0;
            if (k % BAUD == BAUD/2) begin
                exp = frame_bit(8'hA5, k / BAUD);
                checks++; if (TX !== exp) begin errors++; $display("FAIL tx_bit%0d got=%b exp=%b", k / BAUD, TX, exp); end
            end
            if (bus.resp_sent === 1'b1) sent_at = k;
            // request while busy must not disturb the frame
            if (k == 40) begin bus.resp = 8'h3C; bus.send_resp = 1'b1; end
        end
        checks++; if (sent_at != 10*BAUD) begin errors++; $display("FAIL tx_resp_sent_at got=%0d exp=%0d", sent_at, 10*BAUD); end
        wait_cycles(1);
        checks++; if (bus.resp_sent !== 1'b0 || TX !== 1'b1) begin errors++; $display("FAIL tx_idle_after got=%b/%b exp=0/1", bus.resp_sent, TX); end
        wait_cycles(10);
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL tx_ignored_busy got=%b exp=1", TX); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        int   start, frame, sent, off;
        logic exp;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h5A;
        start = 0; frame = 0; sent = 0;
        bus.resp = bytes[0];
        bus.send_resp = 1'b1;
        wait_cycles(1);
        bus.send_resp = 1'b0;
        for (int k = 1; k <= 600 && sent < 3; k++) begin
            wait_cycles(1);
            bus.send_resp = 1'b0;
            off = k - start;
            if (off % BAUD == BAUD/2 && off < 10*BAUD) begin
                exp = frame_bit(bytes[frame], off / BAUD);
                checks++; if (TX !== exp) begin errors++; $display("FAIL b2b_f%0d_bit%0d got=%b exp=%b", frame, off / BAUD, TX, exp); end
            end
            if (bus.resp_sent === 1'b1) begin
                checks++; if (off != 10*BAUD) begin errors++; $display("FAIL b2b_sent_f%0d got=%0d exp=%0d", frame, off, 10*BAUD); end
                sent++;
                if (sent < 3) begin
                    bus.resp = bytes[sent];
                    bus.send_resp = 1'b1;
                    start = k + 1;
                    frame = sent;
                end
            end
        end
        checks++; if (sent != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", sent); end
    endtask

    task automatic test_reset_midframe;
        int seen;
        bus.resp = 8'hA5;
        bus.send_resp = 1'b1;
        wait_cycles(1);
        bus.send_resp = 1'b0;
        wait_cycles(50);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midreset_tx got=%b exp=1", TX); end
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            wait_cycles(1);
            if (bus.resp_sent === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midreset_resp_sent got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset;
        test_reset_midframe;
        test_cmd;
        test_rx_errors;
        test_timeout;
        test_tx;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
